// File: rtl/pipe_pkg.sv
// Shared stage indices, default widths and sizing helper
// for the N-stage pipeline controller.
package pipe_pkg;

  localparam int STG_ID  = 0;
  localparam int STG_EX  = 1;
  localparam int STG_MEM = 2;
  localparam int STG_CMT = 3;
  localparam int STG_WB  = 4;

  localparam int DEF_N      = 5;
  localparam int DEF_BUS_W  = 192;
  localparam int DEF_KEEP_W = 32;
  localparam int DEF_CNT_W  = 32;

  // bits needed to hold the values 0..n
  function automatic int clog2_p1(input int n);
    int r;
    r = 0;
    while ((1 << r) < (n + 1)) r++;
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline stage: valid bit plus bus register with
// advance, bubble and kill (PC-trail keep) behaviour.
import pipe_pkg::*;

module pipe_stage_reg #(
  parameter int BUS_W  = DEF_BUS_W,
  parameter int KEEP_W = DEF_KEEP_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             allow_in,
  input  logic             src_ok,
  input  logic             kill,
  input  logic             bubble,
  input  logic [BUS_W-1:0] din,
  output logic             valid,
  output logic [BUS_W-1:0] bus
);

  logic [BUS_W-1:0] kill_val;

  // killed stages keep only the low PC field for debug
  always_comb begin
    kill_val = '0;
    for (int b = 0; b < BUS_W; b++)
      kill_val[b] = (b < KEEP_W) ? din[b] : 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      bus   <= '0;
    end else if (kill) begin
      valid <= 1'b0;
      bus   <= kill_val;
    end else if (allow_in) begin
      if (src_ok && !bubble) begin
        valid <= 1'b1;
        bus   <= din;
      end else begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pipe_ctrl_n.sv
// N-stage valid/allow_in pipeline controller with partial
// flush, debug PC retention and performance counters.
import pipe_pkg::*;

module pipe_ctrl_n #(
  parameter  int N      = DEF_N,
  parameter  int BUS_W  = DEF_BUS_W,
  parameter  int KEEP_W = DEF_KEEP_W,
  parameter  int CNT_W  = DEF_CNT_W,
  localparam int FW     = clog2_p1(N)
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N*BUS_W-1:0] stage_in_bus,
  input  logic [N-1:0]       stage_over,
  input  logic               flush_valid,
  input  logic [FW-1:0]      flush_stage,
  output logic [N-1:0]       stage_valid,
  output logic [N*BUS_W-1:0] stage_bus,
  output logic [N-1:0]       stage_allow_in,
  output logic               retire,
  output logic [FW-1:0]      occupancy,
  output logic [CNT_W-1:0]   retire_cnt,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  logic         fl_act;
  logic [N-1:0] src_ok;
  logic [N-1:0] kill;
  logic [N-1:0] bubble;

  assign fl_act = flush_valid & (flush_stage != '0);

  // chain from the oldest stage back to the youngest
  always_comb begin
    logic a;
    a = ~stage_valid[N-1] | stage_over[N-1];
    stage_allow_in = '0;
    stage_allow_in[N-1] = a;
    for (int i = N - 2; i >= 0; i--) begin
      a = ~stage_valid[i] | (stage_over[i] & a);
      stage_allow_in[i] = a;
    end
  end

  assign in_ready = stage_allow_in[0] | fl_act;
  assign retire   = stage_valid[N-1] & stage_over[N-1];

  for (genvar i = 0; i < N; i++) begin : g_stage
    if (i == 0) begin : g_src0
      assign src_ok[i] = in_valid;
    end else begin : g_srcn
      assign src_ok[i] = stage_valid[i-1] & stage_over[i-1];
    end

    assign kill[i]   = fl_act & (flush_stage > FW'(i));
    assign bubble[i] = fl_act & (flush_stage == FW'(i));

    pipe_stage_reg #(
      .BUS_W  (BUS_W),
      .KEEP_W (KEEP_W)
    ) u_reg (
      .clk      (clk),
      .rst_n    (resetn),
      .allow_in (stage_allow_in[i]),
      .src_ok   (src_ok[i]),
      .kill     (kill[i]),
      .bubble   (bubble[i]),
      .din      (stage_in_bus[i*BUS_W +: BUS_W]),
      .valid    (stage_valid[i]),
      .bus      (stage_bus[i*BUS_W +: BUS_W])
    );
  end

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < N; i++)
      occupancy = occupancy + {{(FW-1){1'b0}}, stage_valid[i]};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      retire_cnt <= '0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
    end else begin
      if (retire)
        retire_cnt <= retire_cnt + CNT_W'(1);
      if (in_valid && !in_ready)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (fl_act)
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_ctrl_n.sv
// Scoreboard bench for pipe_ctrl_n: directed beats, stall,
// full/partial flush, flush+retire and async reset.
module tb_pipe_ctrl_n;

  localparam int N  = 5;
  localparam int BW = 64;
  localparam int KW = 32;
  localparam int CW = 32;
  localparam int FW = 3;

  logic            clk = 1'b0;
  logic            resetn;
  logic            in_valid;
  logic            in_ready;
  logic [N*BW-1:0] stage_in_bus;
  logic [N-1:0]    stage_over;
  logic            flush_valid;
  logic [FW-1:0]   flush_stage;
  logic [N-1:0]    stage_valid;
  logic [N*BW-1:0] stage_bus;
  logic [N-1:0]    stage_allow_in;
  logic            retire;
  logic [FW-1:0]   occupancy;
  logic [CW-1:0]   retire_cnt;
  logic [CW-1:0]   stall_cnt;
  logic [CW-1:0]   flush_cnt;

  logic [BW-1:0]   fetch;
  logic [BW-1:0]   sb[$];
  int              total = 0;
  int              passed = 0;

  // passthrough datapath: stage i loads stage i-1's bus
  assign stage_in_bus = {stage_bus[(N-1)*BW-1:0], fetch};

  always #5 clk = ~clk;

  pipe_ctrl_n #(
    .N      (N),
    .BUS_W  (BW),
    .KEEP_W (KW),
    .CNT_W  (CW)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .stage_in_bus   (stage_in_bus),
    .stage_over     (stage_over),
    .flush_valid    (flush_valid),
    .flush_stage    (flush_stage),
    .stage_valid    (stage_valid),
    .stage_bus      (stage_bus),
    .stage_allow_in (stage_allow_in),
    .retire         (retire),
    .occupancy      (occupancy),
    .retire_cnt     (retire_cnt),
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt)
  );

  function automatic logic [BW-1:0] sbus(input int i);
    return stage_bus[i*BW +: BW];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  // monitor: every retired beat must match the scoreboard head
  always @(negedge clk) begin
    if (resetn === 1'b1 && retire === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL retire_unexpected: got %h want none",
                 sbus(N-1));
      end else begin
        logic [BW-1:0] e;
        e = sb.pop_front();
        chk("retire_data", sbus(N-1), e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [BW-1:0] base, input int stp,
                      input int npush);
    for (int k = 0; k < N; k++) begin
      fetch = base + BW'(stp * k);
      in_valid = 1'b1;
      if (k < npush) sb.push_back(fetch);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0;
    while (occupancy != 0 && n < 30) begin
      tick();
      n++;
    end
    chk("drain_occ", 64'(occupancy), 64'd0);
  endtask

  task automatic wait_retire(input int target);
    int n = 0;
    while (retire_cnt != CW'(target) && n < 30) begin
      tick();
      n++;
    end
    chk("retire_cnt", 64'(retire_cnt), 64'(target));
  endtask

  initial begin
    int rc0;
    resetn = 1'b0;
    in_valid = 1'b0;
    fetch = '0;
    stage_over = '1;
    flush_valid = 1'b0;
    flush_stage = '0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    chk("rst_valid", 64'(stage_valid), 64'd0);
    chk("rst_allow", 64'(stage_allow_in), 64'h1f);
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_bus4", sbus(4), 64'd0);
    chk("rst_cnt", 64'(retire_cnt | stall_cnt | flush_cnt), 64'd0);
    tick();

    // streaming beats 1..8
    for (int k = 1; k <= 8; k++) begin
      fetch = BW'(k);
      in_valid = 1'b1;
      sb.push_back(fetch);
      if (k == 6) begin
        @(negedge clk);
        chk("t1_occ", 64'(occupancy), 64'd5);
        chk("t1_bus4", sbus(4), 64'd1);
        chk("t1_retire", 64'(retire), 64'd1);
      end
      tick();
    end
    in_valid = 1'b0;
    wait_retire(8);
    drain();

    // stall: over[2]=0 for 3 cycles
    fill(64'h11, 1, 5);
    fetch = 64'h16;
    in_valid = 1'b1;
    sb.push_back(fetch);
    stage_over = 5'b11011;
    @(negedge clk);
    chk("t2_ready", 64'(in_ready), 64'd0);
    repeat (3) tick();
    stage_over = '1;
    @(negedge clk);
    chk("t2_valid", 64'(stage_valid), 64'b00111);
    chk("t2_bus0", sbus(0), 64'h15);
    chk("t2_bus1", sbus(1), 64'h14);
    chk("t2_bus2", sbus(2), 64'h13);
    chk("t2_stall", 64'(stall_cnt), 64'd3);
    tick();
    drain();

    // full flush, no retire (over=0)
    fill(64'hABCD_0000_0040_0010, 4, 0);
    stage_over = '0;
    flush_valid = 1'b1;
    flush_stage = 3'd5;
    fetch = 64'hABCD_0000_0040_0024;
    in_valid = 1'b1;
    @(negedge clk);
    chk("t3_ready", 64'(in_ready), 64'd1);
    tick();
    flush_valid = 1'b0;
    in_valid = 1'b0;
    stage_over = '1;
    @(negedge clk);
    chk("t3_valid", 64'(stage_valid), 64'd0);
    chk("t3_bus0", sbus(0), 64'h0000_0000_0040_0024);
    chk("t3_bus1", sbus(1), 64'h0000_0000_0040_0020);
    chk("t3_bus2", sbus(2), 64'h0000_0000_0040_001c);
    chk("t3_bus3", sbus(3), 64'h0000_0000_0040_0018);
    chk("t3_bus4", sbus(4), 64'h0000_0000_0040_0014);
    chk("t3_fcnt", 64'(flush_cnt), 64'd1);
    tick();

    // partial flush F=2
    fill(64'hDEAD_0000_0000_0100, 1, 3);
    flush_valid = 1'b1;
    flush_stage = 3'd2;
    fetch = 64'hDEAD_0000_0000_01FF;
    in_valid = 1'b1;
    @(negedge clk);
    chk("t4_ready", 64'(in_ready), 64'd1);
    tick();
    flush_valid = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("t4_valid", 64'(stage_valid), 64'b11000);
    chk("t4_bus3", sbus(3), 64'hDEAD_0000_0000_0102);
    chk("t4_bus4", sbus(4), 64'hDEAD_0000_0000_0101);
    chk("t4_bus0", sbus(0), 64'h0000_0000_0000_01FF);
    chk("t4_bus1", sbus(1), 64'h0000_0000_0000_0104);
    chk("t4_fcnt", 64'(flush_cnt), 64'd2);
    tick();
    drain();

    // flush F=5 coinciding with retire of stage 4
    fill(64'hBEEF_0000_0000_0200, 1, 1);
    rc0 = int'(retire_cnt);
    flush_valid = 1'b1;
    flush_stage = 3'd5;
    @(negedge clk);
    chk("t5_retire", 64'(retire), 64'd1);
    tick();
    flush_valid = 1'b0;
    @(negedge clk);
    chk("t5_rcnt", 64'(retire_cnt), 64'(rc0 + 1));
    chk("t5_valid", 64'(stage_valid), 64'd0);
    chk("t5_fcnt", 64'(flush_cnt), 64'd3);
    tick();

    // asynchronous reset mid-stream
    for (int k = 0; k < 3; k++) begin
      fetch = 64'h300 + 64'(k);
      in_valid = 1'b1;
      tick();
    end
    #2 resetn = 1'b0;
    #1;
    chk("t6_valid", 64'(stage_valid), 64'd0);
    chk("t6_rcnt", 64'(retire_cnt), 64'd0);
    chk("t6_fcnt", 64'(flush_cnt), 64'd0);
    in_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    tick();
    fetch = 64'h400;
    in_valid = 1'b1;
    sb.push_back(fetch);
    tick();
    in_valid = 1'b0;
    wait_retire(1);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
